param_register_bank: RTL and testbench
======================================

// Module: param_register_bank
// PURPOSE
//  Parametrised successor to the 4x16 sel/wr/addr register block: NUM_REGS x DATA_W registers.
//  Adds byte-enable writes, read-only and clear-on-read register masks, and a registered ack/err_code response.
//  Adds a saturating error counter. Sits on the local control bus as the standard config/status register slice.
// PARAMETERS
//  DATA_W    16   register and data bus width; must be a multiple of 8
//  NUM_REGS  4    number of implemented registers; must be >= 2 and <= 2**ADDR_W
//  ADDR_W    2    address width
//  RO_MASK   '0   NUM_REGS bits; bit i=1 -> register i is read-only and never changes after reset
//  COR_MASK  '0   NUM_REGS bits; bit i=1 -> register i is cleared to 0 in the cycle after it is read
//  RESET_VAL '0   DATA_W reset value for every register
//  ERRCNT_W  8    error counter width
// PORTS
//  clk       in   1             single clock; all state updates on posedge clk
//  reset     in   1             synchronous, active-high reset
//  sel       in   1             access request, sampled each posedge
//  wr        in   1             1 = write, 0 = read (valid only when sel=1)
//  addr      in   ADDR_W        register index
//  be        in   DATA_W/8      byte enables for writes; be[k] gates wdata[8k+7:8k]
//  wdata     in   DATA_W        write data
//  rdata     out  DATA_W        registered read data
//  ack       out  1             one-cycle pulse, registered: the access in the previous cycle completed
//  err_code  out  2             reg_bank_pkg::err_e, valid when ack=1, else ERR_NONE
//  err_count out  ERRCNT_W      saturating count of errored accesses
// BEHAVIOUR
//  Reset: reset is sampled at posedge, so it takes effect at the next posedge regardless of sel.
//   All registers = RESET_VAL; rdata=0, ack=0, err_code=ERR_NONE, err_count=0.
//   A reset arriving mid-sequence cancels any pending access with no ack.
//  Every posedge with sel=1 is one access. Latency is one cycle: the ack, err_code and rdata updates are
//   visible after that same posedge. No back-pressure: back-to-back accesses on consecutive cycles are legal.
//  Valid write (addr<NUM_REGS, RO_MASK[addr]=0): for each k with be[k]=1, byte k of reg[addr] <= byte k of wdata.
//   Bytes with be[k]=0 keep their value. be=0 is a legal no-op write with ERR_NONE. rdata holds its value.
//  Read (wr=0, addr<NUM_REGS): rdata <= reg[addr] (the pre-clear value).
//   If COR_MASK[addr]=1, reg[addr] <= 0 on the same edge, so the next read returns 0.
//  A read on the cycle after a write to the same addr returns the newly written value. No stale data.
//  Errors (ack=1, no state change except err_count; rdata holds):
//   ERR_ADDR  - addr >= NUM_REGS, for read or write; write data is discarded.
//   ERR_RO    - write to a register with RO_MASK[addr]=1; a read of a RO register is legal.
//  err_count increments by 1 per errored access and saturates at 2**ERRCNT_W-1. No wrap. Cleared only by reset.
//  sel=0: nothing changes; ack=0, err_code=ERR_NONE; rdata holds its last value.
//  wr, addr, be and wdata are don't-care when sel=0.
// STRUCTURE
//  reg_bank_pkg: typedef enum logic[1:0] err_e {ERR_NONE=0, ERR_ADDR=1, ERR_RO=2};
//   also holds the byte-merge function byte_merge(old, new, be).
//  Register array held in a generate loop over NUM_REGS, with per-register RO/COR handling.
//  Sub-module sat_counter #(ERRCNT_W): inc, clk, reset -> count; holds at max.
// TESTING (defaults except where noted; RO_MASK=4'b0100, COR_MASK=4'b1000 for the bench)
//  1 reset=1 for 2 cycles, then read addr 0..3 -> rdata=0000 each, ack=1 each, err_code=NONE, err_count=0.
//  2 write addr0 wdata=1234 be=11, then read addr0 -> 1234.
//    Then write addr0 wdata=ABCD be=01, then read -> 12CD. Then be=00 write -> still 12CD.
//  3 write addr2 (RO) wdata=5678 -> ack=1, err_code=ERR_RO, err_count=1.
//    Read addr2 -> 0000; with ADDR_W=3, access addr 5 -> ERR_ADDR, err_count=2.
//  4 write addr3 (COR) wdata=BEEF, read addr3 -> BEEF, read addr3 again -> 0000.
//  5 write addr1 wdata=5678, read addr1 -> 5678, then sel=0 for 3 cycles.
//    -> rdata stays 5678, ack=0; assert reset during a write to addr1 -> reg1=0, no ack.
//  6 ERRCNT_W=2: 5 errored accesses -> err_count sequence 1,2,3,3,3.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared types and helpers for the parametrised register bank.
// err_e response codes, byte_merge byte-lane write helper.
package reg_bank_pkg;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_ADDR = 2'd1,
    ERR_RO   = 2'd2
  } err_e;

  // Widest register the merge helper handles; callers size-cast.
  localparam int MAX_W = 256;

  function automatic logic [MAX_W-1:0] byte_merge(
    input logic [MAX_W-1:0]   old_v,
    input logic [MAX_W-1:0]   new_v,
    input logic [MAX_W/8-1:0] be
  );
    logic [MAX_W-1:0] res;
    res = old_v;
    for (int k = 0; k < MAX_W/8; k++)
      if (be[k]) res[8*k +: 8] = new_v[8*k +: 8];
    return res;
  endfunction

endpackage

// File: rtl/param_register_bank_sat_counter.sv
// Saturating up-counter used for the bank error count.
// Ports: clk, reset (sync, high), inc -> count (holds at all-ones).
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (inc && count != '1)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/param_register_bank.sv
// NUM_REGS x DATA_W config/status register slice with byte enables.
// Ports: clk, reset, sel, wr, addr, be, wdata -> rdata, ack, err_code, err_count.
module param_register_bank
  import reg_bank_pkg::*;
#(
  parameter int                   DATA_W    = 16,
  parameter int                   NUM_REGS  = 4,
  parameter int                   ADDR_W    = 2,
  parameter logic [NUM_REGS-1:0]  RO_MASK   = '0,
  parameter logic [NUM_REGS-1:0]  COR_MASK  = '0,
  parameter logic [DATA_W-1:0]    RESET_VAL = '0,
  parameter int                   ERRCNT_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sel,
  input  logic                wr,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata,
  output logic                ack,
  output err_e                err_code,
  output logic [ERRCNT_W-1:0] err_count
);

  logic [DATA_W-1:0] q [NUM_REGS];
  logic [DATA_W-1:0] rd_val;
  logic              addr_ok;
  logic              ro_hit;
  err_e              err_nxt;

  // Widen by one bit so the compare stays meaningful when
  // NUM_REGS == 2**ADDR_W.
  assign addr_ok =
    {1'b0, addr} < (ADDR_W+1)'(NUM_REGS);

  always_comb begin
    rd_val = '0;
    ro_hit = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr == ADDR_W'(i)) begin
        rd_val = q[i];
        ro_hit = RO_MASK[i];
      end
    end
  end

  always_comb begin
    err_nxt = ERR_NONE;
    if (!addr_ok)
      err_nxt = ERR_ADDR;
    else if (wr && ro_hit)
      err_nxt = ERR_RO;
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    localparam bit RO  = RO_MASK[i];
    localparam bit COR = COR_MASK[i];
    logic hit;
    assign hit = sel && (addr == ADDR_W'(i));

    always_ff @(posedge clk) begin
      if (reset)
        q[i] <= RESET_VAL;
      else if (hit && wr && !RO)
        q[i] <= DATA_W'(byte_merge(
          MAX_W'(q[i]), MAX_W'(wdata),
          (MAX_W/8)'(be)));
      // Clear lands on the read edge; rdata keeps
      // the pre-clear value.
      else if (hit && !wr && COR)
        q[i] <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata    <= '0;
      ack      <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      ack      <= sel;
      err_code <= sel ? err_nxt : ERR_NONE;
      if (sel && !wr && addr_ok)
        rdata <= rd_val;
    end
  end

  sat_counter #(.W(ERRCNT_W)) u_errcnt (
    .clk   (clk),
    .reset (reset),
    .inc   (sel && err_nxt != ERR_NONE),
    .count (err_count)
  );

endmodule

// File: tb/tb_param_register_bank.sv
// Directed bench for param_register_bank.
// u0: 8-bit err count, u1: 2-bit err count for saturation.
module tb_param_register_bank;
  import reg_bank_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sel = 1'b0;
  logic        wr = 1'b0;
  logic [2:0]  addr = '0;
  logic [1:0]  be = '0;
  logic [15:0] wdata = '0;

  logic [15:0] rdata0, rdata1;
  logic        ack0, ack1;
  err_e        err0, err1;
  logic [7:0]  cnt0;
  logic [1:0]  cnt1;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  param_register_bank #(
    .ADDR_W(3), .RO_MASK(4'b0100),
    .COR_MASK(4'b1000), .ERRCNT_W(8)
  ) u0 (
    .clk(clk), .reset(reset), .sel(sel), .wr(wr),
    .addr(addr), .be(be), .wdata(wdata),
    .rdata(rdata0), .ack(ack0), .err_code(err0),
    .err_count(cnt0)
  );

  param_register_bank #(
    .ADDR_W(3), .RO_MASK(4'b0100),
    .COR_MASK(4'b1000), .ERRCNT_W(2)
  ) u1 (
    .clk(clk), .reset(reset), .sel(sel), .wr(wr),
    .addr(addr), .be(be), .wdata(wdata),
    .rdata(rdata1), .ack(ack1), .err_code(err1),
    .err_count(cnt1)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h, want %h",
                  tag, got, exp);
  endtask

  // Drive one cycle; outputs sampled 1ns after the edge.
  task automatic acc(
    input logic        s,
    input logic        w,
    input logic [2:0]  a,
    input logic [1:0]  b,
    input logic [15:0] d
  );
    sel = s; wr = w; addr = a; be = b; wdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [2:0] a,
                    input logic [15:0] exp,
                    input string tag);
    acc(1'b1, 1'b0, a, 2'b00, 16'h0);
    chk({tag, ".rdata"}, 32'(rdata0), 32'(exp));
    chk({tag, ".ack"}, 32'(ack0), 32'd1);
    chk({tag, ".err"}, 32'(err0), 32'(ERR_NONE));
  endtask

  initial begin
    @(posedge clk); #1;
    reset = 1'b1;
    acc(1'b1, 1'b1, 3'd0, 2'b11, 16'hFFFF);
    acc(1'b0, 1'b0, 3'd0, 2'b00, 16'h0);
    chk("rst.rdata", 32'(rdata0), 32'h0);
    chk("rst.ack", 32'(ack0), 32'd0);
    chk("rst.err", 32'(err0), 32'(ERR_NONE));
    chk("rst.cnt", 32'(cnt0), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++)
      rd(3'(i), 16'h0000, $sformatf("rd%0d", i));
    chk("t1.cnt", 32'(cnt0), 32'd0);

    acc(1'b1, 1'b1, 3'd0, 2'b11, 16'h1234);
    chk("w0.ack", 32'(ack0), 32'd1);
    chk("w0.hold", 32'(rdata0), 32'h0);
    rd(3'd0, 16'h1234, "r0a");
    acc(1'b1, 1'b1, 3'd0, 2'b01, 16'hABCD);
    rd(3'd0, 16'h12CD, "r0b");
    acc(1'b1, 1'b1, 3'd0, 2'b00, 16'hFFFF);
    chk("be0.ack", 32'(ack0), 32'd1);
    chk("be0.err", 32'(err0), 32'(ERR_NONE));
    rd(3'd0, 16'h12CD, "r0c");

    acc(1'b1, 1'b1, 3'd2, 2'b11, 16'h5678);
    chk("ro.ack", 32'(ack0), 32'd1);
    chk("ro.err", 32'(err0), 32'(ERR_RO));
    chk("ro.cnt", 32'(cnt0), 32'd1);
    rd(3'd2, 16'h0000, "r2");
    acc(1'b1, 1'b0, 3'd5, 2'b00, 16'h0);
    chk("ad.err", 32'(err0), 32'(ERR_ADDR));
    chk("ad.cnt", 32'(cnt0), 32'd2);
    acc(1'b1, 1'b1, 3'd0, 2'b11, 16'h9999);
    acc(1'b1, 1'b1, 3'd4, 2'b11, 16'h7777);
    chk("adw.err", 32'(err0), 32'(ERR_ADDR));
    chk("adw.cnt", 32'(cnt0), 32'd3);
    chk("adw.hold", 32'(rdata0), 32'h0);
    rd(3'd0, 16'h9999, "r0d");

    acc(1'b1, 1'b1, 3'd3, 2'b11, 16'hBEEF);
    rd(3'd3, 16'hBEEF, "cor1");
    rd(3'd3, 16'h0000, "cor2");

    acc(1'b1, 1'b1, 3'd1, 2'b11, 16'h5678);
    rd(3'd1, 16'h5678, "r1");
    for (int i = 0; i < 3; i++) begin
      acc(1'b0, 1'b1, 3'd1, 2'b11, 16'h1111);
      chk("idle.rdata", 32'(rdata0), 32'h5678);
      chk("idle.ack", 32'(ack0), 32'd0);
      chk("idle.err", 32'(err0), 32'(ERR_NONE));
    end
    rd(3'd1, 16'h5678, "r1b");

    reset = 1'b1;
    acc(1'b1, 1'b1, 3'd1, 2'b11, 16'hFFFF);
    chk("rw.ack", 32'(ack0), 32'd0);
    chk("rw.rdata", 32'(rdata0), 32'h0);
    chk("rw.cnt", 32'(cnt0), 32'd0);
    reset = 1'b0;
    rd(3'd1, 16'h0000, "r1c");
    rd(3'd0, 16'h0000, "r0e");

    for (int i = 1; i <= 5; i++) begin
      acc(1'b1, 1'b1, 3'd2, 2'b11, 16'h4321);
      chk($sformatf("sat%0d", i), 32'(cnt1),
          (i < 3) ? 32'(i) : 32'd3);
      chk($sformatf("cnt%0d", i), 32'(cnt0), 32'(i));
      chk($sformatf("sat%0d.err", i), 32'(err1),
          32'(ERR_RO));
    end
    acc(1'b0, 1'b0, 3'd0, 2'b00, 16'h0);
    chk("sat.hold", 32'(cnt1), 32'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
